// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> WB, with a sticky TRAP on bad opcodes.
// Optional performance counters are compiled in with the SEQ_PERF_COUNTERS_EN macro.
//
// state  | meaning
// FETCH  | request instruction, load instr on ack
// DECODE | classify opcode in instr[6:0]
// EXEC   | datapath busy, held while stall=1
// WB     | single-cycle pc_we/rf_we strobe
// TRAP   | illegal opcode seen, parked until reset
module core_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    input  logic            stall,
    output logic            pc_we,
    output logic            rf_we,
    output logic            illegal,
    output logic [2:0]      state
`ifdef SEQ_PERF_COUNTERS_EN
    ,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_TRAP   = 3'd4
    } state_t;

    localparam logic [XLEN-1:0] INSTR_NOP = XLEN'(32'h0000_0013);

    state_t          state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d;

    function automatic logic opcode_legal(input logic [6:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            7'b0010011, 7'b0110111, 7'b0010111, 7'b0110011: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            instr_q <= INSTR_NOP;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = opcode_legal(instr_q[6:0]) ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (!stall) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Strobes are masked by reset so an aborted instruction never writes back.
    always_comb begin
        imem_req = reset && (state_q == S_FETCH);
        pc_we    = reset && (state_q == S_WB);
        rf_we    = reset && (state_q == S_WB);
        illegal  = (state_q == S_TRAP);
        state    = state_q;
        instr    = instr_q;
    end

`ifdef SEQ_PERF_COUNTERS_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instret_q, instret_d;

    always_comb begin
        cycle_d   = cycle_q + 32'd1;
        instret_d = instret_q;
        if (state_q == S_WB) begin
            instret_d = instret_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: instruction-level reference model pushes per-cycle
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_core_sequencer;

    localparam int FETCH  = 0;
    localparam int DECODE = 1;
    localparam int EXEC   = 2;
    localparam int WB     = 3;
    localparam int TRAP   = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        stall;
    logic        pc_we;
    logic        rf_we;
    logic        illegal;
    logic [2:0]  state;
`ifdef SEQ_PERF_COUNTERS_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    always #5 clk = ~clk;

    core_sequencer #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .stall      (stall),
        .pc_we      (pc_we),
        .rf_we      (rf_we),
        .illegal    (illegal),
        .state      (state)
`ifdef SEQ_PERF_COUNTERS_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    typedef struct {
        int          st;
        bit          req;
        bit          we;
        bit          ill;
        logic [31:0] ins;
        logic [31:0] cyc;
        logic [31:0] ret;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic [31:0] m_instr = NOP;
    logic [31:0] m_cyc = 32'd0;
    logic [31:0] m_ret = 32'd0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("state",   32'(state),    32'(e.st));
            check("imem_req", 32'(imem_req), 32'(e.req));
            check("pc_we",   32'(pc_we),    32'(e.we));
            check("rf_we",   32'(rf_we),    32'(e.we));
            check("illegal", 32'(illegal),  32'(e.ill));
            check("instr",   instr,         e.ins);
`ifdef SEQ_PERF_COUNTERS_EN
            check("cycle_cnt",   cycle_cnt,   e.cyc);
            check("instret_cnt", instret_cnt, e.ret);
`endif
        end
    end

    function automatic bit legal_op(input logic [6:0] op);
        return (op == 7'h13) || (op == 7'h37) || (op == 7'h17) || (op == 7'h33);
    endfunction

    // One clock of stimulus; expected outputs follow from the state the instruction is in.
    task automatic step(input int st, input bit rst_n, input bit ack, input logic [31:0] rd,
                        input bit stl);
        exp_t e;
        @(posedge clk);
        #1;
        reset      = rst_n;
        imem_ack   = ack;
        imem_rdata = rd;
        stall      = stl;
        e.st  = st;
        e.req = rst_n && (st == FETCH);
        e.we  = rst_n && (st == WB);
        e.ill = (st == TRAP);
        e.ins = m_instr;
        e.cyc = m_cyc;
        e.ret = m_ret;
        sb.push_back(e);
        if (!rst_n) begin
            m_instr = NOP;
            m_cyc   = 32'd0;
            m_ret   = 32'd0;
        end else begin
            if (st == FETCH && ack) m_instr = rd;
            m_cyc = m_cyc + 32'd1;
            if (st == WB) m_ret = m_ret + 32'd1;
        end
    endtask

    // Instruction-level model: d wait cycles before ack, s stall cycles in EXEC,
    // reset asserted at cycle index rst_at of the instruction (negative = never).
    task automatic run_instr(input logic [31:0] word, input int d, input int s, input int rst_at);
        int seq[$];
        bit ackq[$];
        bit stq[$];
        int rpos;
        logic [31:0] rd;
        rpos = rst_at;
        for (int i = 0; i <= d; i++) begin
            seq.push_back(FETCH); ackq.push_back(i == d); stq.push_back(1'($urandom));
        end
        seq.push_back(DECODE); ackq.push_back(1'($urandom)); stq.push_back(1'($urandom));
        if (legal_op(word[6:0])) begin
            for (int i = 0; i <= s; i++) begin
                seq.push_back(EXEC); ackq.push_back(1'($urandom)); stq.push_back(i < s);
            end
            seq.push_back(WB); ackq.push_back(1'($urandom)); stq.push_back(1'($urandom));
        end else begin
            for (int i = 0; i < 2 + int'($urandom_range(0, 2)); i++) begin
                seq.push_back(TRAP); ackq.push_back(1'b1); stq.push_back(1'($urandom));
            end
            if (rpos < 0 || rpos >= seq.size()) rpos = seq.size() - 1;
        end
        for (int i = 0; i < seq.size(); i++) begin
            rd = (seq[i] == FETCH && ackq[i]) ? word : $urandom;
            if (i == rpos) begin
                step(seq[i], 1'b0, ackq[i], rd, stq[i]);
                return;
            end
            step(seq[i], 1'b1, ackq[i], rd, stq[i]);
        end
    endtask

    function automatic logic [31:0] rand_word(input bit want_legal);
        logic [31:0] r;
        logic [6:0]  op;
        logic [6:0]  ops [4];
        ops[0] = 7'h13; ops[1] = 7'h37; ops[2] = 7'h17; ops[3] = 7'h33;
        r = $urandom;
        if (want_legal) begin
            op = ops[$urandom_range(0, 3)];
        end else begin
            op = 7'($urandom_range(0, 127));
            while (legal_op(op)) op = 7'($urandom_range(0, 127));
        end
        return {r[31:7], op};
    endfunction

    initial begin
        reset      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        stall      = 1'b0;
        repeat (2) @(posedge clk);

        run_instr(32'h0050_0093, 0, 0, -1);
        run_instr(32'h00a0_0113, 5, 0, -1);
        run_instr(32'h0020_81b3, 0, 3, -1);
        run_instr(32'h0000_0073, 0, 0, -1);
        run_instr(32'h0010_0093, 0, 2, 3);
        run_instr(32'h1234_5037, 2, 0, 2);
        run_instr(32'h0000_1017, 0, 0, -1);
        run_instr(32'h0000_2037, 0, 0, -1);
        run_instr(32'h0030_0033, 0, 0, -1);

        for (int n = 0; n < 150; n++) begin
            int d;
            int s;
            int r;
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0;
            s = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1;
            run_instr(rand_word($urandom_range(0, 9) != 0), d, s, r);
        end

        step(FETCH, 1'b1, 1'b0, 32'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter XLEN, default 32, sets the instruction and data width.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on clk rising edge).
REQ-004 imem_req  output  1  instruction-fetch request to instruction memory.
REQ-005 imem_ack  input  1  fetch complete; imem_rdata valid in the same cycle.
REQ-006 imem_rdata  input  XLEN  fetched instruction word.
REQ-007 instr  output  XLEN  instruction register; feeds the decoder and datapath.
REQ-008 stall  input  1  datapath hold request, honoured only in EXEC.
REQ-009 pc_we  output  1  PC update strobe.
REQ-010 rf_we  output  1  register-file write strobe.
REQ-011 illegal  output  1  sticky illegal-opcode flag.
REQ-012 state  output  3  current FSM state encoding, for debug.

Function
REQ-013 The FSM SHALL have the states FETCH=0, DECODE=1, EXEC=2, WB=3 and TRAP=4; all other encodings SHALL go to FETCH on the next cycle.
REQ-014 FETCH: imem_req SHALL be 1; when imem_ack=1, instr SHALL load imem_rdata and the FSM SHALL go to DECODE; otherwise the FSM SHALL stay in FETCH.
REQ-015 imem_ack SHALL be ignored in all states other than FETCH; instr SHALL change only on an accepted ack.
REQ-016 DECODE: if instr[6:0] is one of 0010011, 0110111, 0010111 or 0110011, the FSM SHALL go to EXEC; otherwise it SHALL go to TRAP.
REQ-017 EXEC: if stall=1 the FSM SHALL hold in EXEC; otherwise it SHALL go to WB.
REQ-018 WB: pc_we and rf_we SHALL both be 1 for exactly this one cycle, and the FSM SHALL then go to FETCH.
REQ-019 TRAP: illegal SHALL be 1, pc_we, rf_we and imem_req SHALL be 0, and the FSM SHALL remain in TRAP until reset.
REQ-020 Outputs SHALL be Moore (decoded from the state register only), and imem_req SHALL also be gated by reset=1.
REQ-021 The minimum instruction period SHALL be 4 cycles (ack in the first FETCH cycle, no stall).
REQ-022 An ack and a reset in the same cycle: reset SHALL win and instr SHALL not load.

Reset
REQ-023 With reset=0 at a clk edge: state=FETCH, instr=0x00000013 (NOP), illegal=0.
REQ-024 While reset=0: pc_we=0, rf_we=0 and imem_req=0.
REQ-025 Reset asserted in any state, including mid-fetch, EXEC stall or TRAP, SHALL abort the current instruction with no pc_we or rf_we pulse.
REQ-026 The first cycle after reset deasserts SHALL be FETCH with imem_req=1.

Configuration
REQ-027 Macro SEQ_PERF_COUNTERS_EN: when defined, the block SHALL add outputs cycle_cnt (32) and instret_cnt (32); when undefined, these ports and their logic SHALL be absent and all other behaviour SHALL be identical.
REQ-028 When enabled, cycle_cnt SHALL increment by 1 every cycle with reset=1, including in TRAP, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-029 When enabled, instret_cnt SHALL increment by 1 only in WB cycles and SHALL wrap from 0xFFFFFFFF to 0.
REQ-030 When enabled, both counters SHALL clear to 0 on reset.

Verification
REQ-031 Reset, then imem_ack=1 with imem_rdata=0x00500093 in the first FETCH cycle, stall=0 -> DECODE, EXEC, WB in turn; pc_we=rf_we=1 only on cycle 4; instr=0x00500093.
REQ-032 imem_ack held 0 for 5 cycles, then 1 -> imem_req stays 1 for all 6 cycles; instr loads only on cycle 6.
REQ-033 stall=1 for 3 cycles in EXEC -> FSM holds in EXEC with no strobes; WB follows on the first cycle with stall=0.
REQ-034 imem_rdata=0x00000073 -> TRAP with illegal=1; a later imem_ack=1 is ignored; reset=0 returns the FSM to FETCH with illegal=0.
REQ-035 reset=0 asserted during EXEC -> no WB pulse; instr=0x00000013; with SEQ_PERF_COUNTERS_EN defined, both counters read 0.
REQ-036 With SEQ_PERF_COUNTERS_EN defined, 3 back-to-back legal instructions with immediate acks -> instret_cnt=3 and cycle_cnt=12 at the third return to FETCH.
